// File: rtl/dtc_pkg.sv
// dtc_pkg: shared DTC link constants, FSM state type and checksum.
// Used by the reply transmitter and the receive side.
package dtc_pkg;

  localparam logic [7:0] DTC_PREAMBLE   = 8'hD5;
  localparam int         DTC_FRAME_BITS = 80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } dtc_state_t;

  function automatic logic [7:0] dtc_chk(
    input logic [31:0] addr,
    input logic [31:0] data
  );
    return addr[31:24] ^ addr[23:16]
         ^ addr[15:8]  ^ addr[7:0]
         ^ data[31:24] ^ data[23:16]
         ^ data[15:8]  ^ data[7:0];
  endfunction

endpackage

// File: rtl/dtc_reply_tx_bit_timer.sv
// dtc_bit_timer: divides rdoclk down to one tick per serial bit.
// Restart realigns the bit grid to a freshly loaded frame.
module dtc_bit_timer #(
  parameter int BIT_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic en,
  output logic bit_tick
);

  localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_DIV - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = en && (cnt == LAST);

  // Cycle counter within the current bit period
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dtc_reply_tx.sv
// dtc_reply_tx: serialises DTC read replies into 80-bit frames.
// A one-entry pending buffer holds a reply that arrives mid-frame.
module dtc_reply_tx
  import dtc_pkg::*;
#(
  parameter int         BIT_DIV  = 2,
  parameter int         GAP_BITS = 4,
  parameter logic [7:0] PREAMBLE = DTC_PREAMBLE
) (
  input  logic        rdoclk,
  input  logic        reset,
  input  logic [31:0] reply_addr,
  input  logic [31:0] reply_data,
  input  logic        reply_rdy,
  output logic        frame_st,
  output logic        dtc_tx_bit,
  output logic        dtc_tx_en,
  output logic [15:0] frame_cnt,
  output logic        drop_err
);

  localparam int GAP_LEN = GAP_BITS * BIT_DIV;
  localparam int GW = $clog2(GAP_LEN + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LEN - 1);
  localparam logic [6:0] BIT_LAST = 7'(DTC_FRAME_BITS - 1);

  dtc_state_t state, state_n;

  logic          rdy_q;
  logic          rdy_edge;
  logic [79:0]   sh;
  logic [6:0]    bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          pend_v;
  logic [31:0]   pend_addr;
  logic [31:0]   pend_data;
  logic          bit_tick;
  logic          last_bit;
  logic          gap_end;
  logic          load_port;
  logic          load_pend;
  logic          pend_cap;
  logic          drop;
  logic          frame_done;

  assign rdy_edge = reply_rdy & ~rdy_q;
  assign last_bit = (bit_cnt == BIT_LAST);
  assign gap_end  = (state == GAP) && (gap_cnt == GAP_LAST);

  assign frame_done = (state == SHIFT) && bit_tick && last_bit;

  assign dtc_tx_en  = (state == SHIFT);
  assign dtc_tx_bit = dtc_tx_en & sh[79];
  assign frame_st   = (state != IDLE) | pend_v;

  dtc_bit_timer #(
    .BIT_DIV (BIT_DIV)
  ) u_timer (
    .clk      (rdoclk),
    .reset    (reset),
    .restart  (load_port | load_pend),
    .en       (state == SHIFT),
    .bit_tick (bit_tick)
  );

  // State register
  always_ff @(posedge rdoclk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, frame load selection and pending capture/drop decisions
  always_comb begin
    state_n   = state;
    load_port = 1'b0;
    load_pend = 1'b0;
    pend_cap  = 1'b0;
    drop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (rdy_edge) begin
          load_port = 1'b1;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (frame_done) begin
          state_n = GAP;
        end
        if (rdy_edge) begin
          pend_cap = ~pend_v;
          drop     = pend_v;
        end
      end
      GAP: begin
        if (gap_end) begin
          if (pend_v) begin
            load_pend = 1'b1;
            state_n   = SHIFT;
          end else if (rdy_edge) begin
            load_port = 1'b1;
            state_n   = SHIFT;
          end else begin
            state_n = IDLE;
          end
        end
        if (rdy_edge && !(gap_end && !pend_v)) begin
          pend_cap = ~pend_v;
          drop     = pend_v;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Reply edge detector
  always_ff @(posedge rdoclk) begin
    if (reset) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= reply_rdy;
    end
  end

  // Frame shift register and bit position
  always_ff @(posedge rdoclk) begin
    if (reset) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (load_port) begin
      sh <= {PREAMBLE, reply_addr, reply_data,
             dtc_chk(reply_addr, reply_data)};
      bit_cnt <= '0;
    end else if (load_pend) begin
      sh <= {PREAMBLE, pend_addr, pend_data,
             dtc_chk(pend_addr, pend_data)};
      bit_cnt <= '0;
    end else if ((state == SHIFT) && bit_tick) begin
      sh      <= {sh[78:0], 1'b0};
      bit_cnt <= bit_cnt + 7'd1;
    end
  end

  // Inter-frame gap cycle counter
  always_ff @(posedge rdoclk) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if ((state == GAP) && !gap_end) begin
      gap_cnt <= gap_cnt + 1'b1;
    end else begin
      gap_cnt <= '0;
    end
  end

  // One-entry pending reply buffer
  always_ff @(posedge rdoclk) begin
    if (reset) begin
      pend_v    <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else if (pend_cap) begin
      pend_v    <= 1'b1;
      pend_addr <= reply_addr;
      pend_data <= reply_data;
    end else if (load_pend) begin
      pend_v <= 1'b0;
    end
  end

  // Completed-frame counter and sticky drop flag
  always_ff @(posedge rdoclk) begin
    if (reset) begin
      frame_cnt <= '0;
      drop_err  <= 1'b0;
    end else begin
      frame_cnt <= frame_cnt + 16'(frame_done);
      drop_err  <= drop_err | drop;
    end
  end

endmodule
